// File: rtl/seq_mult.sv
// Sequential radix-2 shift-add multiplier with valid/ready handshakes on both sides.
// Signed operands are multiplied as magnitudes and the product sign is applied on completion.
module seq_mult #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   count;
    logic               neg;

    logic               use_signed;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] next_acc;
    logic [2*WIDTH-1:0] product;
    logic               last_iter;

    // Upper half of acc accumulates partial products; lower half holds the multiplier shifting out.
    always_comb begin
        use_signed = signed_mode & SIGNED_EN;
        mag_a      = (use_signed && a[WIDTH-1]) ? -a : a;
        mag_b      = (use_signed && b[WIDTH-1]) ? -b : b;
        sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        next_acc   = {sum, acc[WIDTH-1:1]};
        product    = neg ? -next_acc : next_acc;
        last_iter  = (count == CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mcand <= '0;
            acc   <= '0;
            count <= '0;
            neg   <= 1'b0;
            p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= mag_a;
                        acc   <= {{WIDTH{1'b0}}, mag_b};
                        count <= CNT_W'(WIDTH);
                        neg   <= use_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= next_acc;
                    count <= count - CNT_W'(1);
                    if (last_iter) begin
                        p     <= product;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_mult.sv
// Directed and randomised checks of seq_mult; a signed and an unsigned-only instance run in lockstep.
module tb_seq_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;

    logic        inReadyU;
    logic        outValidU;
    logic [15:0] pUnsigned;
    logic        busyU;

    int assertCount  = 0;
    int failureCount = 0;

    always #5 clk = ~clk;

    seq_mult #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
        .out_ready(out_ready), .p(p), .busy(busy)
    );

    seq_mult #(.WIDTH(8), .SIGNED_EN(1'b0)) dutUnsigned (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReadyU),
        .a(a), .b(b), .signed_mode(signed_mode), .out_valid(outValidU),
        .out_ready(out_ready), .p(pUnsigned), .busy(busyU)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failureCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // One full transaction: accept, scramble operands, time the latency, stall, then release.
    task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB, input logic sm,
                                 input int stall, input logic [15:0] expS, input logic [15:0] expU,
                                 input string tag);
        int cyc;
        logic [15:0] held;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
        a = opA; b = opB; signed_mode = sm; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~opA; b = opB ^ 8'h5A; signed_mode = ~sm;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput({tag, "_lat"}, 32'(cyc), 32'd8);
        checkOutput({tag, "_p"}, 32'(p), 32'(expS));
        checkOutput({tag, "_pu"}, 32'(pUnsigned), 32'(expU));
        held = p;
        for (int s = 0; s < stall; s++) begin
            in_valid = s[0];
            @(posedge clk); #1;
            checkOutput({tag, "_stallv"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_stallp"}, 32'(p), 32'(held));
            checkOutput({tag, "_stallr"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        checkOutput({tag, "_drop"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_noacc"}, 32'(busy), 32'd0);
        checkOutput({tag, "_keep"}, 32'(p), 32'(expS));
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rm;
        int          ia;
        int          ib;
        logic [15:0] expS;
        logic [15:0] expU;

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        a = 8'h00; b = 8'h00; signed_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_p", 32'(p), 32'd0);
        checkOutput("rst_ready_u", 32'(inReadyU), 32'd1);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;

        applyStimulus(8'hFF, 8'hFF, 1'b0, 0, 16'hFE01, 16'hFE01, "uns_ff");
        applyStimulus(8'h80, 8'h80, 1'b1, 0, 16'h4000, 16'h4000, "s_80_80");
        applyStimulus(8'hFF, 8'h7F, 1'b1, 0, 16'hFF81, 16'h7E81, "s_ff_7f");
        applyStimulus(8'h80, 8'h01, 1'b1, 0, 16'hFF80, 16'h0080, "s_80_01");
        applyStimulus(8'h00, 8'h9C, 1'b1, 0, 16'h0000, 16'h0000, "s_00_9c");
        applyStimulus(8'hFF, 8'hFF, 1'b1, 0, 16'h0001, 16'hFE01, "sen_ff");
        applyStimulus(8'h12, 8'h34, 1'b0, 5, 16'h03A8, 16'h03A8, "bp");

        a = 8'h7B; b = 8'h6D; signed_mode = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("mid_ready", 32'(in_ready), 32'd1);
        checkOutput("mid_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_busy0", 32'(busy), 32'd0);
        checkOutput("mid_p", 32'(p), 32'd0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        applyStimulus(8'h03, 8'hFB, 1'b1, 0, 16'hFFF1, 16'h02F1, "post_rst");

        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rm = 1'($urandom_range(0, 1));
            ia = rm ? int'($signed(ra)) : int'(ra);
            ib = rm ? int'($signed(rb)) : int'(rb);
            expS = 16'(ia * ib);
            expU = 16'(int'(ra) * int'(rb));
            applyStimulus(ra, rb, rm, int'($urandom_range(0, 3)), expS, expU, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failureCount);
        $finish;
    end

endmodule
